// File: rtl/vpu_pkg.sv
// Shared types and default sizes for the VPU -> unified-buffer writeback path.
package vpu_pkg;

  localparam int VPU_DATA_W = 16;
  localparam int VPU_SIZE   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

  typedef logic [VPU_SIZE-1:0][VPU_DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/lane_fifo.sv
// Single-clock per-lane FIFO with synchronous flush; extra pointer bit tells
// full from empty. Push while full is accepted only if a pop frees a slot.
module lane_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/vpu_ub_writeback.sv
// Deskews SIZE skewed VPU lanes through per-lane FIFOs and writes packed rows
// to the unified buffer at base + row*stride over a valid/ready port.
module vpu_ub_writeback
  import vpu_pkg::*;
#(
  parameter int DATA_W     = VPU_DATA_W,
  parameter int SIZE       = VPU_SIZE,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int ROWS_W     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [ROWS_W-1:0]            stride_i,
  input  logic [ROWS_W-1:0]            num_rows_i,
  input  logic [SIZE-1:0][DATA_W-1:0]  lane_data_i,
  input  logic [SIZE-1:0]              lane_valid_i,
  output logic                         ub_wr_valid_o,
  input  logic                         ub_wr_ready_i,
  output logic [ADDR_W-1:0]            ub_wr_addr_o,
  output logic [SIZE-1:0][DATA_W-1:0]  ub_wr_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_overflow_o,
  output logic                         err_stray_o
);

  wb_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [ADDR_W-1:0]          out_addr_q, out_addr_d;
  logic [ROWS_W-1:0]          stride_q, stride_d;
  logic [ROWS_W-1:0]          num_rows_q, num_rows_d;
  logic [ROWS_W-1:0]          rows_issued_q, rows_issued_d;
  logic [ROWS_W-1:0]          rows_accepted_q, rows_accepted_d;
  logic                       out_valid_q, out_valid_d;
  logic [SIZE-1:0][DATA_W-1:0] out_data_q, out_data_d;
  logic                       err_ovf_q, err_ovf_d;
  logic                       err_stray_q, err_stray_d;

  logic [SIZE-1:0][DATA_W-1:0] fifo_data;
  logic [SIZE-1:0]            fifo_full;
  logic [SIZE-1:0]            fifo_empty;
  logic [SIZE-1:0]            lane_push;
  logic                       run;
  logic                       start_ok;
  logic                       handshake;
  logic                       pop;
  logic                       last_accept;

  assign run         = (state_q == RUN);
  assign start_ok    = (state_q == IDLE) && start_i;
  assign handshake   = out_valid_q && ub_wr_ready_i;
  assign lane_push   = run ? lane_valid_i : '0;
  // A row leaves only when every lane has its sample and the output slot frees up.
  assign pop         = run && !(|fifo_empty) && (rows_issued_q < num_rows_q) &&
                       (!out_valid_q || ub_wr_ready_i);
  assign last_accept = run && handshake && (rows_accepted_q == num_rows_q - 1'b1);

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    lane_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (start_ok),
      .push_i      (lane_push[i]),
      .push_data_i (lane_data_i[i]),
      .pop_i       (pop),
      .pop_data_o  (fifo_data[i]),
      .full_o      (fifo_full[i]),
      .empty_o     (fifo_empty[i])
    );
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    out_addr_d      = out_addr_q;
    stride_d        = stride_q;
    num_rows_d      = num_rows_q;
    rows_issued_d   = rows_issued_q;
    rows_accepted_d = rows_accepted_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    err_ovf_d       = err_ovf_q | (|(lane_push & fifo_full & ~{SIZE{pop}}));
    err_stray_d     = err_stray_q | (!run && (|lane_valid_i));

    if (pop) begin
      out_valid_d   = 1'b1;
      out_data_d    = fifo_data;
      out_addr_d    = addr_q;
      addr_d        = addr_q + ADDR_W'(stride_q);
      rows_issued_d = rows_issued_q + 1'b1;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
    if (handshake) rows_accepted_d = rows_accepted_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d         = (num_rows_i == '0) ? DONE : RUN;
          addr_d          = base_addr_i;
          stride_d        = stride_i;
          num_rows_d      = num_rows_i;
          rows_issued_d   = '0;
          rows_accepted_d = '0;
          err_ovf_d       = 1'b0;
          err_stray_d     = 1'b0;
        end
      end
      RUN:     if (last_accept) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      out_addr_q      <= '0;
      stride_q        <= '0;
      num_rows_q      <= '0;
      rows_issued_q   <= '0;
      rows_accepted_q <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      err_ovf_q       <= 1'b0;
      err_stray_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      out_addr_q      <= out_addr_d;
      stride_q        <= stride_d;
      num_rows_q      <= num_rows_d;
      rows_issued_q   <= rows_issued_d;
      rows_accepted_q <= rows_accepted_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      err_ovf_q       <= err_ovf_d;
      err_stray_q     <= err_stray_d;
    end
  end

  assign ub_wr_valid_o  = out_valid_q;
  assign ub_wr_addr_o   = out_addr_q;
  assign ub_wr_data_o   = out_data_q;
  assign busy_o         = run;
  assign done_o         = (state_q == DONE);
  assign err_overflow_o = err_ovf_q;
  assign err_stray_o    = err_stray_q;

endmodule

// File: tb/tb_vpu_ub_writeback.sv
// Directed bench for vpu_ub_writeback: expected rows go into a scoreboard queue,
// a negedge monitor checks every UB transfer, stall stability and done pulses.
module tb_vpu_ub_writeback;
  import vpu_pkg::*;

  localparam int SIZE = VPU_SIZE;

  typedef struct packed {
    logic [9:0] addr;
    lane_vec_t  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  stride;
  logic [9:0]  num_rows;
  lane_vec_t   lane_data;
  logic [SIZE-1:0] lane_valid;
  logic        ub_wr_valid;
  logic        ub_wr_ready;
  logic [9:0]  ub_wr_addr;
  lane_vec_t   ub_wr_data;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic        err_stray;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_cnt   = 0;
  int   done_cnt = 0;
  logic       prev_stall = 1'b0;
  logic       prev_done  = 1'b0;
  logic [9:0] hold_addr;
  lane_vec_t  hold_data;

  vpu_ub_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .base_addr_i    (base_addr),
    .stride_i       (stride),
    .num_rows_i     (num_rows),
    .lane_data_i    (lane_data),
    .lane_valid_i   (lane_valid),
    .ub_wr_valid_o  (ub_wr_valid),
    .ub_wr_ready_i  (ub_wr_ready),
    .ub_wr_addr_o   (ub_wr_addr),
    .ub_wr_data_o   (ub_wr_data),
    .busy_o         (busy),
    .done_o         (done),
    .err_overflow_o (err_overflow),
    .err_stray_o    (err_stray)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: transfers complete at the next posedge when valid && ready here.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 1'b0);
      end
      prev_done = done;
      if (prev_stall) begin
        check("stall_valid_held", ub_wr_valid, 1'b1);
        if (ub_wr_valid) begin
          check("stall_addr_stable", ub_wr_addr, hold_addr);
          check("stall_data_stable", ub_wr_data, hold_data);
        end
      end
      if (ub_wr_valid && ub_wr_ready) begin
        wr_cnt++;
        prev_stall = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", ub_wr_addr, ub_wr_data);
        end else begin
          e = sb.pop_front();
          check("wr_addr", ub_wr_addr, e.addr);
          check("wr_data", ub_wr_data, e.data);
        end
      end else if (ub_wr_valid) begin
        prev_stall = 1'b1;
        hold_addr  = ub_wr_addr;
        hold_data  = ub_wr_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic lane_vec_t mk_row(input int r, input int off);
    lane_vec_t v;
    for (int i = 0; i < SIZE; i++) v[i] = 16'(100 * r + i + off);
    return v;
  endfunction

  task automatic push_exp(input logic [9:0] a, input lane_vec_t d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic start_job(input logic [9:0] b, input logic [9:0] s, input logic [9:0] n);
    base_addr = b;
    stride    = s;
    num_rows  = n;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Lane i carries row r at cycle r+i (systolic skew).
  task automatic stream(input int n, input int off, input logic [SIZE-1:0] mask);
    for (int c = 0; c < n + SIZE - 1; c++) begin
      lane_valid = '0;
      for (int i = 0; i < SIZE; i++) begin
        if (mask[i] && (c - i) >= 0 && (c - i) < n) begin
          lane_valid[i] = 1'b1;
          lane_data[i]  = 16'(100 * (c - i) + i + off);
        end
      end
      step();
    end
    lane_valid = '0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int k = 0;
    while (done_cnt == d0 && k < 300) begin
      step();
      k++;
    end
    repeat (3) step();
    check(name, done_cnt - d0, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int        d0;
    int        w0;
    lane_vec_t r;
    logic [9:0] t4_addr [3];
    t4_addr = '{10'h3FE, 10'h001, 10'h004};

    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; num_rows = '0;
    lane_data = '0; lane_valid = '0; ub_wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ub_wr_valid, 1'b0);
    check("rst_addr", ub_wr_addr, 10'h000);
    check("rst_data", ub_wr_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", err_overflow, 1'b0);
    check("rst_stray", err_stray, 1'b0);
    rst = 1'b0;
    step();

    // 1: skewed rows, ready high
    ub_wr_ready = 1'b1;
    for (int rr = 0; rr < 4; rr++) push_exp(10'h010 + 10'(rr), mk_row(rr, 0));
    d0 = done_cnt; w0 = wr_cnt;
    start_job(10'h010, 10'd1, 10'd4);
    check("t1_busy", busy, 1'b1);
    stream(4, 0, '1);
    wait_done(d0, "t1_done");
    check("t1_writes", wr_cnt - w0, 4);
    check("t1_busy_after", busy, 1'b0);
    check("t1_ovf", err_overflow, 1'b0);
    check("t1_stray", err_stray, 1'b0);

    // 2: backpressure for 20 cycles during the stream
    ub_wr_ready = 1'b0;
    for (int rr = 0; rr < 4; rr++) push_exp(10'h020 + 10'(rr), mk_row(rr, 2000));
    d0 = done_cnt; w0 = wr_cnt;
    start_job(10'h020, 10'd1, 10'd4);
    stream(4, 2000, '1);
    repeat (9) step();
    check("t2_valid_stalled", ub_wr_valid, 1'b1);
    check("t2_no_write_yet", wr_cnt - w0, 0);
    ub_wr_ready = 1'b1;
    wait_done(d0, "t2_done");
    check("t2_writes", wr_cnt - w0, 4);
    check("t2_ovf", err_overflow, 1'b0);

    // 3: overflow on lane 0 only
    ub_wr_ready = 1'b0;
    d0 = done_cnt; w0 = wr_cnt;
    start_job(10'h100, 10'd1, 10'd16);
    for (int k = 0; k < 16; k++) begin
      lane_valid = 8'h01;
      lane_data[0] = 16'(1000 + k);
      step();
    end
    lane_valid = '0;
    check("t3_ovf_at_depth", err_overflow, 1'b0);
    lane_valid = 8'h01;
    lane_data[0] = 16'd1016;
    step();
    lane_valid = '0;
    step();
    check("t3_ovf_set", err_overflow, 1'b1);
    check("t3_no_valid", ub_wr_valid, 1'b0);
    check("t3_no_write", wr_cnt - w0, 0);
    for (int rr = 0; rr < 16; rr++) begin
      r = mk_row(rr, 0);
      r[0] = 16'(1000 + rr);
      push_exp(10'h100 + 10'(rr), r);
    end
    ub_wr_ready = 1'b1;
    stream(16, 0, 8'hFE);
    wait_done(d0, "t3_done");
    check("t3_writes", wr_cnt - w0, 16);
    check("t3_ovf_sticky", err_overflow, 1'b1);

    // 4: address wrap with stride 3
    for (int rr = 0; rr < 3; rr++) push_exp(t4_addr[rr], mk_row(rr, 5000));
    d0 = done_cnt; w0 = wr_cnt;
    start_job(10'h3FE, 10'd3, 10'd3);
    check("t4_ovf_cleared", err_overflow, 1'b0);
    stream(3, 5000, '1);
    wait_done(d0, "t4_done");
    check("t4_writes", wr_cnt - w0, 3);

    // 5: zero rows, start during RUN, stray valid
    d0 = done_cnt; w0 = wr_cnt;
    start_job(10'h050, 10'd1, 10'd0);
    check("t5_zero_done", done, 1'b1);
    check("t5_zero_busy", busy, 1'b0);
    repeat (4) step();
    check("t5_zero_done_cnt", done_cnt - d0, 1);
    check("t5_zero_no_write", wr_cnt - w0, 0);
    push_exp(10'h200, mk_row(0, 300));
    push_exp(10'h202, mk_row(1, 300));
    d0 = done_cnt; w0 = wr_cnt;
    start_job(10'h200, 10'd2, 10'd2);
    start_job(10'h300, 10'd7, 10'd5);
    stream(2, 300, '1);
    wait_done(d0, "t5_run_done");
    check("t5_run_writes", wr_cnt - w0, 2);
    lane_valid = 8'h10;
    step();
    lane_valid = '0;
    check("t5_stray_set", err_stray, 1'b1);
    d0 = done_cnt;
    start_job(10'h000, 10'd1, 10'd0);
    check("t5_stray_cleared", err_stray, 1'b0);
    repeat (3) step();

    // 6: reset after 2 of 4 rows, then a fresh job
    ub_wr_ready = 1'b0;
    for (int rr = 0; rr < 4; rr++) push_exp(10'h040 + 10'(rr), mk_row(rr, 700));
    w0 = wr_cnt;
    start_job(10'h040, 10'd1, 10'd4);
    stream(4, 700, '1);
    step();
    ub_wr_ready = 1'b1;
    step();
    step();
    ub_wr_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_writes_before_rst", wr_cnt - w0, 2);
    check("t6_sb_left", sb.size(), 2);
    sb.delete();
    step();
    check("t6_rst_valid", ub_wr_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_addr", ub_wr_addr, 10'h000);
    rst = 1'b0;
    ub_wr_ready = 1'b1;
    repeat (6) step();
    check("t6_no_write_after_rst", wr_cnt - w0, 2);
    for (int rr = 0; rr < 4; rr++) push_exp(10'h080 + 10'(2 * rr), mk_row(rr, 900));
    d0 = done_cnt; w0 = wr_cnt;
    start_job(10'h080, 10'd2, 10'd4);
    stream(4, 900, '1);
    wait_done(d0, "t6_fresh_done");
    check("t6_fresh_writes", wr_cnt - w0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
